// File: rtl/operand_fetch.sv
// operand_fetch: operand-read stage with writeback bypass, a pending-write
// scoreboard for RAW/WAW interlocks, and a registered output bundle.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        decoded-instruction handshake
//   in_op, in_rs1/2, in_rs1/2_en, in_rd, in_rd_en   decoded instruction
//   rf_raddr1/2, rf_rdata1/2   register-file read port (async read data)
//   wb_we, wb_waddr, wb_wdata  writeback port, mirrors the RF write port
//   out_valid / out_ready      fetched-operand bundle handshake
//   out_op, out_rd, out_rd_en, out_a, out_b   registered bundle
//   stall_cnt                  saturating count of hazard-stall cycles
module operand_fetch #(
    parameter int unsigned OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [2:0]     in_rs1,
    input  logic [2:0]     in_rs2,
    input  logic           in_rs1_en,
    input  logic           in_rs2_en,
    input  logic [2:0]     in_rd,
    input  logic           in_rd_en,
    output logic [2:0]     rf_raddr1,
    output logic [2:0]     rf_raddr2,
    input  logic [7:0]     rf_rdata1,
    input  logic [7:0]     rf_rdata2,
    input  logic           wb_we,
    input  logic [2:0]     wb_waddr,
    input  logic [7:0]     wb_wdata,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_op,
    output logic [2:0]     out_rd,
    output logic           out_rd_en,
    output logic [7:0]     out_a,
    output logic [7:0]     out_b,
    output logic [7:0]     stall_cnt
);

    localparam int unsigned DW = 8;
    localparam int unsigned NREG = 8;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic            clr1;
    logic            clr2;
    logic            clrd;
    logic            raw;
    logic            waw;
    logic            hazard;
    logic            accept;

    // Read addressing, bypass, hazard detection and handshake
    always_comb begin
        rf_raddr1 = in_rs1;
        rf_raddr2 = in_rs2;
        clr1      = wb_we && (wb_waddr == in_rs1);
        clr2      = wb_we && (wb_waddr == in_rs2);
        clrd      = wb_we && (wb_waddr == in_rd);
        op1       = clr1 ? wb_wdata : rf_rdata1;
        op2       = clr2 ? wb_wdata : rf_rdata2;
        // A writeback landing this cycle resolves the hazard on that register
        raw       = (in_rs1_en && pend[in_rs1] && !clr1) ||
                    (in_rs2_en && pend[in_rs2] && !clr2);
        waw       = in_rd_en && pend[in_rd] && !clrd;
        hazard    = raw || waw;
        in_ready  = !hazard && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
    end

    // Scoreboard next state: clear on writeback, set on accept; set wins
    always_comb begin
        pend_nxt = pend;
        if (wb_we) begin
            pend_nxt[wb_waddr] = 1'b0;
        end
        if (accept && in_rd_en) begin
            pend_nxt[in_rd] = 1'b1;
        end
    end

    // Output bundle, scoreboard and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            stall_cnt <= '0;
        end else begin
            pend <= pend_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_op    <= in_op;
                out_rd    <= in_rd;
                out_rd_en <= in_rd_en;
                out_a     <= op1;
                out_b     <= op2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && hazard && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus randomized traffic for
// operand_fetch, checked cycle by cycle against a behavioural model of the
// scoreboard, bypass and output bundle. The bench owns the register file.
module tb_operand_fetch;

    localparam int unsigned OPW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [2:0]     in_rs1, in_rs2, in_rd;
    logic           in_rs1_en, in_rs2_en, in_rd_en;
    logic [2:0]     rf_raddr1, rf_raddr2;
    logic [7:0]     rf_rdata1, rf_rdata2;
    logic           wb_we;
    logic [2:0]     wb_waddr;
    logic [7:0]     wb_wdata;
    logic           out_valid, out_ready;
    logic [OPW-1:0] out_op;
    logic [2:0]     out_rd;
    logic           out_rd_en;
    logic [7:0]     out_a, out_b;
    logic [7:0]     stall_cnt;

    // Register file contents (bench-owned, async read)
    logic [7:0] rf [8];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    operand_fetch #(.OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
        .in_rd(in_rd), .in_rd_en(in_rd_en),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rd_en(out_rd_en),
        .out_a(out_a), .out_b(out_b), .stall_cnt(stall_cnt)
    );

    // Reference model state
    bit       m_pend [8];
    bit       m_valid;
    int       m_op, m_rd, m_rd_en, m_a, m_b;
    int       m_stall;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit written_now(input int r);
        return wb_we && (int'(wb_waddr) == r);
    endfunction

    function automatic bit blocked(input int r, input bit used);
        return used && m_pend[r] && !written_now(r);
    endfunction

    function automatic int operand(input int r);
        return written_now(r) ? int'(wb_wdata) : int'(rf[r]);
    endfunction

    function automatic logic [31:0] pend_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 8; i++) w[i] = m_pend[i];
        return w;
    endfunction

    function automatic bit pend_bit(input int r);
        return m_pend[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_valid = 0; m_op = 0; m_rd = 0; m_rd_en = 0; m_a = 0; m_b = 0; m_stall = 0;
    endtask

    // One clock: check handshake before the edge, advance model, check state after
    task automatic step();
        bit h, rdy, acc;
        int a, b;
        bit np [8];
        #1;
        h   = blocked(int'(in_rs1), in_rs1_en) || blocked(int'(in_rs2), in_rs2_en) ||
              blocked(int'(in_rd), in_rd_en);
        rdy = !h && (!m_valid || out_ready);
        acc = in_valid && rdy;
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("rf_raddr1", 32'(rf_raddr1), 32'(in_rs1));
        check("rf_raddr2", 32'(rf_raddr2), 32'(in_rs2));
        a = operand(int'(in_rs1));
        b = operand(int'(in_rs2));
        np = m_pend;
        if (wb_we) np[wb_waddr] = 1'b0;
        if (acc && in_rd_en) np[in_rd] = 1'b1;
        @(posedge clk);
        #1;
        if (wb_we) rf[wb_waddr] = wb_wdata;
        if (rst) begin
            model_reset();
        end else begin
            m_pend = np;
            if (acc) begin
                m_valid = 1; m_op = int'(in_op); m_rd = int'(in_rd);
                m_rd_en = int'(in_rd_en); m_a = a; m_b = b;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (in_valid && h && m_stall < 255) m_stall++;
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_op", 32'(out_op), 32'(m_op));
        check("out_rd", 32'(out_rd), 32'(m_rd));
        check("out_rd_en", 32'(out_rd_en), 32'(m_rd_en));
        check("out_a", 32'(out_a), 32'(m_a));
        check("out_b", 32'(out_b), 32'(m_b));
        check("pend", 32'(dut.pend), pend_word());
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rs1_en = 0; in_rs2_en = 0;
        in_rd = '0; in_rd_en = 0; wb_we = 0; wb_waddr = '0; wb_wdata = '0; out_ready = 1;
    endtask

    task automatic issue(input int op, input int rs1, input bit e1, input int rs2, input bit e2,
                         input int rd, input bit rde);
        in_valid = 1; in_op = OPW'(op);
        in_rs1 = 3'(rs1); in_rs1_en = e1; in_rs2 = 3'(rs2); in_rs2_en = e2;
        in_rd = 3'(rd); in_rd_en = rde;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'(i * 16 + 1);
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_stall", 32'(stall_cnt), 32'd0);
        rst = 0;

        // Basic fetch
        rf[1] = 8'd5; rf[2] = 8'd9;
        issue(3, 1, 1, 2, 1, 3, 1);
        step();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_a", 32'(out_a), 32'd5);
        check("basic_b", 32'(out_b), 32'd9);
        check("basic_rd", 32'(out_rd), 32'd3);
        check("basic_pend", 32'(dut.pend), 32'h08);

        // RAW stall then writeback bypass
        issue(1, 3, 1, 0, 0, 0, 0);
        step();
        step();
        check("raw_ready", 32'(in_ready), 32'd0);
        check("raw_stall", 32'(stall_cnt), 32'd2);
        wb_we = 1; wb_waddr = 3'd3; wb_wdata = 8'h7A;
        step();
        check("bypass_a", 32'(out_a), 32'h7A);
        check("bypass_pend3", 32'(dut.pend[3]), 32'd0);
        wb_we = 0;

        // Output backpressure
        out_ready = 0;
        issue(2, 1, 1, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) step();
        check("bp_hold_a", 32'(out_a), 32'h7A);
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_stall", 32'(stall_cnt), 32'd2);
        out_ready = 1;
        step();
        check("bp_release_a", 32'(out_a), 32'd5);

        // Same-index set and clear: set wins
        issue(4, 0, 0, 0, 0, 4, 1);
        step();
        wb_we = 1; wb_waddr = 3'd4; wb_wdata = 8'h44;
        step();
        check("setwins_pend4", 32'(dut.pend[4]), 32'd1);
        idle_inputs();

        // Randomized traffic, writebacks biased toward pending registers
        for (int n = 0; n < 600; n++) begin
            int tgt;
            rst = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = OPW'($urandom);
            in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_rd = 3'($urandom);
            in_rs1_en = 1'($urandom); in_rs2_en = 1'($urandom); in_rd_en = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_we = 1'($urandom);
            tgt = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) if (pend_bit((tgt + k) % 8) && $urandom_range(0, 1) == 1) begin
                tgt = (tgt + k) % 8;
                break;
            end
            wb_waddr = 3'(tgt);
            wb_wdata = 8'($urandom);
            step();
        end
        idle_inputs();
        rst = 0;

        // Saturation, then reset with in_valid asserted
        rst = 1;
        step();
        rst = 0;
        issue(5, 0, 0, 0, 0, 5, 1);
        step();
        issue(6, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step();
        check("sat_stall", 32'(stall_cnt), 32'd255);
        rst = 1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pend", 32'(dut.pend), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
